pipe_hazard_ctrl: RTL

//  Central stall/flush/forwarding controller for the 5-stage MIPS pipeline.
//  It generalises the fixed single-cycle load-use stall to a configurable data-memory read latency.
//  It also adds a multi-cycle multiply/divide unit (MDU) interlock and ID-stage branch operand forwarding.

---
 rtl/pipe_hazard_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage MIPS pipeline.
// It handles load-use, ID-branch, multi-cycle load and multi-cycle MDU interlocks, and drives the EX/ID forwarding selects.
module pipe_hazard_ctrl #(
    parameter int RA_W     = 5,
    parameter int LOAD_LAT = 0,
    parameter int MDU_LAT  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [RA_W-1:0] rs_id,
    input  logic [RA_W-1:0] rt_id,
    input  logic            use_rs_id,
    input  logic            use_rt_id,
    input  logic            branch_id,
    input  logic            redirect_id,
    input  logic            mdu_id,
    input  logic [RA_W-1:0] rs_ex,
    input  logic [RA_W-1:0] rt_ex,
    input  logic [RA_W-1:0] wa_ex,
    input  logic [RA_W-1:0] wa_mem,
    input  logic [RA_W-1:0] wa_wb,
    input  logic            rw_ex,
    input  logic            rw_mem,
    input  logic            rw_wb,
    input  logic            mr_ex,
    input  logic            mr_mem,
    output logic            pc_we,
    output logic            ifid_we,
    output logic            ifid_flush,
    output logic            idex_we,
    output logic            idex_flush,
    output logic            exmem_we,
    output logic            exmem_flush,
    output logic            memwb_flush,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic            fwd_rs_id,
    output logic            fwd_rt_id,
    output logic            mdu_busy
);

    localparam bit         MEM_EN   = (LOAD_LAT > 0);
    localparam bit         MDU_EN   = (MDU_LAT > 1);
    localparam logic [3:0] MEM_LOAD = MEM_EN ? 4'(LOAD_LAT - 1) : 4'd0;
    localparam logic [4:0] MDU_LOAD = MDU_EN ? 5'(MDU_LAT - 2) : 5'd0;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        MEMW = 2'd1,
        MDUW = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] memCnt_q, memCnt_d;
    logic [4:0] mduCnt_q, mduCnt_d;
    logic       mduPend_q, mduPend_d;

    logic ldUse, brHaz, idStall;
    logic memEntry, memHold, memRelease, memFreeze, mduFreeze, runMode, idexCapture;

    // Register 0 is hard-wired, so it never creates a hazard or a forward.
    function automatic logic regMatch(input logic [RA_W-1:0] x,
                                      input logic [RA_W-1:0] w,
                                      input logic            rw);
        return rw && (w != '0) && (x == w);
    endfunction

    always_comb begin
        ldUse = (use_rs_id && regMatch(rs_id, wa_ex, mr_ex)) ||
                (use_rt_id && regMatch(rt_id, wa_ex, mr_ex));
        brHaz = branch_id &&
                ((use_rs_id && (regMatch(rs_id, wa_ex, rw_ex) || regMatch(rs_id, wa_mem, mr_mem))) ||
                 (use_rt_id && (regMatch(rt_id, wa_ex, rw_ex) || regMatch(rt_id, wa_mem, mr_mem))));
        idStall = ldUse || brHaz;
    end

    // The entry cycle of a load wait freezes immediately; the last MEMW cycle (count 0) releases the load.
    always_comb begin
        memEntry    = MEM_EN && mr_mem && (state_q != MEMW);
        memHold     = (state_q == MEMW) && (memCnt_q != 4'd0);
        memRelease  = (state_q == MEMW) && (memCnt_q == 4'd0);
        memFreeze   = memEntry || memHold;
        mduFreeze   = !memFreeze && ((state_q == MDUW) || (memRelease && mduPend_q));
        runMode     = !memFreeze && !mduFreeze;
        idexCapture = MDU_EN && runMode && !idStall && mdu_id;
    end

    always_comb begin
        state_d   = state_q;
        memCnt_d  = memCnt_q;
        mduCnt_d  = mduCnt_q;
        mduPend_d = mduPend_q;
        if (memEntry) begin
            state_d   = MEMW;
            memCnt_d  = MEM_LOAD;
            mduPend_d = (state_q == MDUW);
        end else if (memHold) begin
            memCnt_d = memCnt_q - 4'd1;
        end else if (mduFreeze) begin
            mduPend_d = 1'b0;
            if (mduCnt_q == 5'd0) begin
                state_d = RUN;
            end else begin
                state_d  = MDUW;
                mduCnt_d = mduCnt_q - 5'd1;
            end
        end else if (idexCapture) begin
            state_d   = MDUW;
            mduCnt_d  = MDU_LOAD;
            mduPend_d = 1'b0;
        end else begin
            state_d   = RUN;
            mduPend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            memCnt_q  <= 4'd0;
            mduCnt_q  <= 5'd0;
            mduPend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            memCnt_q  <= memCnt_d;
            mduCnt_q  <= mduCnt_d;
            mduPend_q <= mduPend_d;
        end
    end

    // Freeze priority: load wait, then MDU wait, then ID stall, then redirect.
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_we     = 1'b1;
        idex_flush  = 1'b0;
        exmem_we    = 1'b1;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        mdu_busy    = (state_q == MDUW) || ((state_q == MEMW) && mduPend_q);
        if (memFreeze) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_we    = 1'b0;
            memwb_flush = 1'b1;
        end else if (mduFreeze) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_flush = 1'b1;
        end else if (idStall) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
        end else if (redirect_id) begin
            ifid_flush = 1'b1;
        end
        if (!reset) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            ifid_flush  = 1'b1;
            idex_we     = 1'b0;
            idex_flush  = 1'b1;
            exmem_we    = 1'b0;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
            mdu_busy    = 1'b0;
        end
    end

    // A load result in MEM is not ready yet, so only ALU results forward from MEM.
    always_comb begin
        fwd_a     = 2'b00;
        fwd_b     = 2'b00;
        fwd_rs_id = 1'b0;
        fwd_rt_id = 1'b0;
        if (reset) begin
            if (regMatch(rs_ex, wa_mem, rw_mem) && !mr_mem) begin
                fwd_a = 2'b10;
            end else if (regMatch(rs_ex, wa_wb, rw_wb)) begin
                fwd_a = 2'b01;
            end
            if (regMatch(rt_ex, wa_mem, rw_mem) && !mr_mem) begin
                fwd_b = 2'b10;
            end else if (regMatch(rt_ex, wa_wb, rw_wb)) begin
                fwd_b = 2'b01;
            end
            fwd_rs_id = regMatch(rs_id, wa_mem, rw_mem) && !mr_mem;
            fwd_rt_id = regMatch(rt_id, wa_mem, rw_mem) && !mr_mem;
        end
    end

endmodule
